breadboard_sweep_ctrl: RTL and testbench
========================================

// Module: breadboard_sweep_ctrl
// PURPOSE
//   Sequencer for the 4-in/10-out combinational breadboard function block. Steps all 16 input
//   vectors {w,x,y,z} into the block, waits a settle window, then compares its 10 outputs
//   against a golden model driven with the same vector. Counts mismatches and reports
//   pass/fail. Sits between the bring-up bench or host and the breadboard plus golden pair.
// PARAMETERS
//   SETTLE_CYC  4        cycles held in SETTLE before each compare; 0..255, 0 = no SETTLE state
//   OUT_MASK    10'h3FF  per-output compare enable; bit k = r[k]
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   reset, asynchronous, active-high
//   start      in   1   begin a sweep; sampled only in IDLE
//   abort      in   1   synchronous abort to IDLE; wins over start
//   vec        out  4   {w,x,y,z} to the breadboard and the golden model, registered
//   dut_r      in   10  breadboard outputs r9..r0
//   exp_r      in   10  golden outputs r9..r0
//   busy       out  1   high from the cycle after start is accepted until DONE is entered
//   done       out  1   one-cycle pulse at sweep completion
//   pass       out  1   err_count==0 at last completion; held until next start
//   err_count  out  5   mismatching vectors, 0..16
// BEHAVIOUR
//   Reset: state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, idx=0.
//   FSM: IDLE -start-> DRIVE -> SETTLE (SETTLE_CYC cycles; skipped if 0) -> CHECK -> DRIVE for
//     idx+1, or DONE if idx==15 -> IDLE (DONE lasts exactly 1 cycle, done=1 in it).
//   On accepting start: err_count<=0, pass<=0, idx<=0, busy<=1.
//   DRIVE: vec<=idx. vec holds stable through SETTLE and CHECK.
//   CHECK: mismatch = |((dut_r ^ exp_r) & OUT_MASK); if set, err_count<=err_count+1
//     (no saturation; 5 bits covers 16). idx<=idx+1, 4-bit, so 15 wraps to 0 on entry to DONE.
//   Entering DONE: pass<=(next err_count==0), so a mismatch on vector 15 is included; busy<=0.
//   Latency: SETTLE_CYC+2 cycles per vector. done is high in the cycle beginning
//     16*(SETTLE_CYC+2) edges after the edge that sampled start: 96 at default, 32 at 0.
//   Boundaries:
//     - start while busy or in DONE: ignored.
//     - abort in any non-IDLE state: next state IDLE, busy<=0, vec<=0, no done pulse, pass<=0,
//       err_count frozen at its current value.
//     - abort and start together in IDLE: stay IDLE.
//     - rst mid-sweep: every output returns to its reset value immediately (asynchronous).
//     - X on dut_r is sampled only in CHECK.
// CONFIGURATION
//   SWEEP_MISMATCH_LOG_EN defined adds outputs:
//     ff_valid  out 1;  ff_idx  out 4;  ff_mask  out 10
//     - Capture idx and the masked XOR at the first mismatching CHECK of a sweep; ff_valid<=1.
//     - Later mismatches do not overwrite the capture.
//     - All three cleared on reset and on accepted start.
//   SWEEP_MISMATCH_LOG_EN undefined: these ports and their logic are absent; everything else
//     is identical.
// STRUCTURE
//   breadboard_pkg: NUM_IN=4, NUM_OUT=10, NUM_VEC=16, and typedef enum sweep_state_t
//     {IDLE, DRIVE, SETTLE, CHECK, DONE}. Shared with the bench and future breadboard blocks.
//   Sub-module settle_timer (load, count, expire pulse, 8-bit down-counter) owns SETTLE timing.
//   FSM, index, compare and log registers stay in breadboard_sweep_ctrl.
// TESTING
//   1 Loopback exp_r=dut_r=golden, default params, start pulse -> vec steps 0..15, each held
//     6 cycles; done at cycle 96; pass=1; err_count=0.
//   2 Invert dut_r[6] only while vec==5 -> err_count=1, pass=0, ff_valid=1, ff_idx=5,
//     ff_mask=10'h040.
//   3 Same fault with OUT_MASK=10'h3BF -> err_count=0, pass=1, ff_valid=0.
//   4 abort at cycle 30 -> busy=0 and vec=0 next cycle, no done pulse; immediate restart with
//     no fault -> pass=1 at 96 cycles after the restart.
//   5 rst pulse while vec==9 -> all outputs 0 without waiting for a clock edge; start pulsed
//     mid-sweep in a separate run -> ignored, completion time unchanged.
//   6 SETTLE_CYC=0, fault on vec 15 (dut_r=~exp_r) -> done at cycle 32, err_count=1, pass=0,
//     ff_idx=15, ff_mask=10'h3FF.

Source files
------------

// File: rtl/breadboard_pkg.sv
// Shared types and sizes for the breadboard function-block sequencers.
package breadboard_pkg;

  localparam int unsigned NUM_IN  = 4;
  localparam int unsigned NUM_OUT = 10;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned IDX_W   = $clog2(NUM_VEC);
  localparam int unsigned ERR_W   = $clog2(NUM_VEC + 1);
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } sweep_state_t;

  // First-mismatch capture record
  typedef struct packed {
    logic                valid;
    logic [IDX_W-1:0]    idx;
    logic [NUM_OUT-1:0]  mask;
  } mismatch_log_t;

  // Output bits that differ between breadboard and golden, restricted to enabled outputs
  function automatic logic [NUM_OUT-1:0] masked_diff(input logic [NUM_OUT-1:0] dut,
                                                     input logic [NUM_OUT-1:0] gold,
                                                     input logic [NUM_OUT-1:0] mask);
    return (dut ^ gold) & mask;
  endfunction

endpackage

// File: rtl/breadboard_sweep_ctrl_settle_timer.sv
// Down-counter that times the settle window between driving a vector and checking it.
module settle_timer
  import breadboard_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  // Load on request, otherwise count down to zero and hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // Last counting cycle of the window
  assign expire_c = count && (cnt == '0);

endmodule

// File: rtl/breadboard_sweep_ctrl.sv
// Sweeps all 16 input vectors through the breadboard, compares against the golden
// model after a settle window, and reports mismatch count and pass/fail.
// Optional first-mismatch log outputs are enabled by defining SWEEP_MISMATCH_LOG_EN.
module breadboard_sweep_ctrl
  import breadboard_pkg::*;
#(
  parameter int unsigned          SETTLE_CYC = 4,
  parameter logic [NUM_OUT-1:0]   OUT_MASK   = 10'h3FF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [NUM_IN-1:0]   vec,
  input  logic [NUM_OUT-1:0]  dut_r,
  input  logic [NUM_OUT-1:0]  exp_r,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count
`ifdef SWEEP_MISMATCH_LOG_EN
  ,
  output logic                ff_valid,
  output logic [IDX_W-1:0]    ff_idx,
  output logic [NUM_OUT-1:0]  ff_mask
`endif
);

  // Settle timer reload value; the window spans SETTLE_CYC cycles including the expiring one
  localparam logic [TIMER_W-1:0] SETTLE_LOAD =
    (SETTLE_CYC == 0) ? '0 : TIMER_W'(SETTLE_CYC - 1);

  sweep_state_t        state;
  logic [IDX_W-1:0]    idx;
  logic [NUM_OUT-1:0]  diff_c;
  logic                mismatch_c;
  logic                expire_c;
  logic                start_ok_c;

  assign diff_c     = masked_diff(dut_r, exp_r, OUT_MASK);
  assign mismatch_c = |diff_c;
  assign start_ok_c = (state == IDLE) && start && !abort;

  settle_timer #(.W(TIMER_W)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == DRIVE),
    .count    (state == SETTLE),
    .load_val (SETTLE_LOAD),
    .expire_c (expire_c)
  );

  // Sweep sequencer: state, vector index, drive, compare and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        vec   <= '0;
        pass  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok_c) begin
              state     <= DRIVE;
              err_count <= '0;
              pass      <= 1'b0;
              idx       <= '0;
              busy      <= 1'b1;
            end
          end
          DRIVE: begin
            vec   <= NUM_IN'(idx);
            state <= (SETTLE_CYC == 0) ? CHECK : SETTLE;
          end
          SETTLE: begin
            if (expire_c) state <= CHECK;
          end
          CHECK: begin
            if (mismatch_c) err_count <= err_count + ERR_W'(1);
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(NUM_VEC - 1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= !mismatch_c && (err_count == '0);
            end else begin
              state <= DRIVE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SWEEP_MISMATCH_LOG_EN
  mismatch_log_t log_q;

  // Capture only the first mismatching check of each sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_q <= '0;
    end else if (start_ok_c) begin
      log_q <= '0;
    end else if ((state == CHECK) && !abort && mismatch_c && !log_q.valid) begin
      log_q.valid <= 1'b1;
      log_q.idx   <= idx;
      log_q.mask  <= diff_c;
    end
  end

  assign ff_valid = log_q.valid;
  assign ff_idx   = log_q.idx;
  assign ff_mask  = log_q.mask;
`endif

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Self-checking bench for breadboard_sweep_ctrl: three instances (default, masked output 6,
// zero settle) driven from a random golden table with per-instance fault tables.
module tb_breadboard_sweep_ctrl;
  import breadboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [2:0]  abort;
  logic [3:0]  vec [3];
  logic [9:0]  dut_r [3];
  logic [9:0]  exp_r [3];
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  pass;
  logic [4:0]  err_count [3];
`ifdef SWEEP_MISMATCH_LOG_EN
  logic [2:0]  ff_valid;
  logic [3:0]  ff_idx [3];
  logic [9:0]  ff_mask [3];
  bit          m_valid;
  logic [3:0]  m_idx;
  logic [9:0]  m_mask;
`endif

  logic [9:0]  gold [16];
  logic [9:0]  fault [3][16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Golden output and faulted breadboard output for whatever vector each instance drives
  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign exp_r[g] = gold[vec[g]];
    assign dut_r[g] = gold[vec[g]] ^ fault[g][vec[g]];
  end

  breadboard_sweep_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .vec(vec[0]),
    .dut_r(dut_r[0]), .exp_r(exp_r[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_count[0])
`ifdef SWEEP_MISMATCH_LOG_EN
    , .ff_valid(ff_valid[0]), .ff_idx(ff_idx[0]), .ff_mask(ff_mask[0])
`endif
  );

  breadboard_sweep_ctrl #(.OUT_MASK(10'h3BF)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .vec(vec[1]),
    .dut_r(dut_r[1]), .exp_r(exp_r[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_count[1])
`ifdef SWEEP_MISMATCH_LOG_EN
    , .ff_valid(ff_valid[1]), .ff_idx(ff_idx[1]), .ff_mask(ff_mask[1])
`endif
  );

  breadboard_sweep_ctrl #(.SETTLE_CYC(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .vec(vec[2]),
    .dut_r(dut_r[2]), .exp_r(exp_r[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err_count[2])
`ifdef SWEEP_MISMATCH_LOG_EN
    , .ff_valid(ff_valid[2]), .ff_idx(ff_idx[2]), .ff_mask(ff_mask[2])
`endif
  );

  task automatic clear_faults();
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 16; v++) fault[i][v] = '0;
  endtask

  task automatic new_gold();
    for (int v = 0; v < 16; v++) gold[v] = 10'($urandom);
  endtask

  // Reference: mismatches among the first nchk vectors, from the tables and the instance mask
  task automatic model(input int inst, input int nchk, output int e_err);
    logic [9:0] m;
    logic [9:0] d;
    m = (inst == 1) ? 10'h3BF : 10'h3FF;
    e_err = 0;
`ifdef SWEEP_MISMATCH_LOG_EN
    m_valid = 1'b0; m_idx = '0; m_mask = '0;
`endif
    for (int v = 0; v < nchk; v++) begin
      d = ((gold[v] ^ fault[inst][v]) ^ gold[v]) & m;
      if (d != '0) begin
        e_err++;
`ifdef SWEEP_MISMATCH_LOG_EN
        if (!m_valid) begin
          m_valid = 1'b1; m_idx = 4'(v); m_mask = d;
        end
`endif
      end
    end
  endtask

  // One sweep on an instance; optional abort after edge abort_at, optional stray start after restart_at
  task automatic run_sweep(input int inst, input int abort_at, input int restart_at);
    int pv, tot, last, nchk, e_err;
    logic [3:0] e_vec;
    pv   = (inst == 2) ? 2 : 6;
    tot  = 16 * pv;
    last = (abort_at > 0) ? abort_at + 3 : tot + 3;
    @(negedge clk); start[inst] = 1'b1;
    @(posedge clk); #1; start[inst] = 1'b0;
    checks++;
    if (busy[inst] !== 1'b1) begin
      errors++; $display("FAIL busy_after_start inst%0d: got %b want 1", inst, busy[inst]);
    end
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      if (abort_at > 0 && n > abort_at) begin
        checks++;
        if (busy[inst] !== 1'b0 || vec[inst] !== 4'd0 || done[inst] !== 1'b0) begin
          errors++;
          $display("FAIL after_abort inst%0d cyc%0d: busy/vec/done got %b/%0d/%b want 0/0/0",
                   inst, n, busy[inst], vec[inst], done[inst]);
        end
      end else if (n <= tot) begin
        e_vec = 4'((n - 1) / pv);
        checks++;
        if (vec[inst] !== e_vec) begin
          errors++; $display("FAIL vec inst%0d cyc%0d: got %0d want %0d", inst, n, vec[inst], e_vec);
        end
        checks++;
        if (busy[inst] !== (n < tot) || done[inst] !== (n == tot)) begin
          errors++;
          $display("FAIL busy_done inst%0d cyc%0d: got %b/%b want %b/%b",
                   inst, n, busy[inst], done[inst], (n < tot), (n == tot));
        end
      end else begin
        checks++;
        if (done[inst] !== 1'b0 || busy[inst] !== 1'b0) begin
          errors++;
          $display("FAIL post_done inst%0d cyc%0d: busy/done got %b/%b want 0/0",
                   inst, n, busy[inst], done[inst]);
        end
      end
      if (abort_at > 0 && n == abort_at) abort[inst] = 1'b1;
      if (abort_at > 0 && n == abort_at + 1) abort[inst] = 1'b0;
      if (restart_at > 0 && n == restart_at) start[inst] = 1'b1;
      if (restart_at > 0 && n == restart_at + 1) start[inst] = 1'b0;
    end
    nchk = (abort_at > 0) ? abort_at / pv : 16;
    if (nchk > 16) nchk = 16;
    model(inst, nchk, e_err);
    checks++;
    if (err_count[inst] !== 5'(e_err)) begin
      errors++; $display("FAIL err_count inst%0d: got %0d want %0d", inst, err_count[inst], e_err);
    end
    checks++;
    if (pass[inst] !== ((abort_at == 0) && (e_err == 0))) begin
      errors++;
      $display("FAIL pass inst%0d: got %b want %b", inst, pass[inst], ((abort_at == 0) && (e_err == 0)));
    end
`ifdef SWEEP_MISMATCH_LOG_EN
    checks++;
    if (ff_valid[inst] !== m_valid || (m_valid && (ff_idx[inst] !== m_idx || ff_mask[inst] !== m_mask))) begin
      errors++;
      $display("FAIL ff_log inst%0d: got %b/%0d/%h want %b/%0d/%h", inst,
               ff_valid[inst], ff_idx[inst], ff_mask[inst], m_valid, m_idx, m_mask);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vec[i] !== 4'd0 || busy[i] !== 1'b0 || done[i] !== 1'b0 || pass[i] !== 1'b0 ||
          err_count[i] !== 5'd0) begin
        errors++;
        $display("FAIL reset inst%0d: vec/busy/done/pass/err got %0d/%b/%b/%b/%0d want all 0",
                 i, vec[i], busy[i], done[i], pass[i], err_count[i]);
      end
`ifdef SWEEP_MISMATCH_LOG_EN
      checks++;
      if (ff_valid[i] !== 1'b0 || ff_idx[i] !== 4'd0 || ff_mask[i] !== 10'd0) begin
        errors++; $display("FAIL reset_ff inst%0d: got %b/%0d/%h want 0", i, ff_valid[i], ff_idx[i], ff_mask[i]);
      end
`endif
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_loopback();
    clear_faults();
    run_sweep(0, 0, 0);
  endtask

  task automatic test_single_fault();
    clear_faults();
    fault[0][5] = 10'h040;
    run_sweep(0, 0, 0);
  endtask

  task automatic test_masked_fault();
    clear_faults();
    fault[1][5] = 10'h040;
    run_sweep(1, 0, 0);
  endtask

  task automatic test_idle_abort_start();
    @(negedge clk); start[0] = 1'b1; abort[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0; abort[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++; $display("FAIL idle_abort_start cyc%0d: busy/done got %b/%b want 0/0", n, busy[0], done[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    clear_faults();
    fault[0][2] = 10'h201;
    fault[0][7] = 10'h010;
    run_sweep(0, 30, 0);
    clear_faults();
    run_sweep(0, 0, 0);
  endtask

  task automatic test_start_ignored();
    clear_faults();
    fault[0][11] = 10'h100;
    run_sweep(0, 0, 40);
  endtask

  task automatic test_reset_mid();
    bit found;
    clear_faults();
    fault[0][3] = 10'h001;
    found = 1'b0;
    @(negedge clk); start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk); #1;
      if (vec[0] === 4'd9) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_wait: got vec %0d want 9 within 200 cycles", vec[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (vec[0] !== 4'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0 ||
        err_count[0] !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: vec/busy/done/pass/err got %0d/%b/%b/%b/%0d want all 0",
               vec[0], busy[0], done[0], pass[0], err_count[0]);
    end
`ifdef SWEEP_MISMATCH_LOG_EN
    checks++;
    if (ff_valid[0] !== 1'b0 || ff_idx[0] !== 4'd0 || ff_mask[0] !== 10'd0) begin
      errors++; $display("FAIL reset_mid_ff: got %b/%0d/%h want 0", ff_valid[0], ff_idx[0], ff_mask[0]);
    end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_settle0();
    clear_faults();
    fault[2][15] = 10'h3FF;
    run_sweep(2, 0, 0);
  endtask

  task automatic test_random();
    int inst;
    for (int it = 0; it < 8; it++) begin
      new_gold();
      clear_faults();
      inst = int'($urandom_range(0, 2));
      for (int v = 0; v < 16; v++) begin
        case ($urandom_range(0, 5))
          0:       fault[inst][v] = 10'($urandom);
          1:       fault[inst][v] = 10'h040;
          default: fault[inst][v] = '0;
        endcase
      end
      run_sweep(inst, 0, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    abort = '0;
    new_gold();
    clear_faults();
    test_reset();
    test_loopback();
    test_single_fault();
    test_masked_fault();
    test_idle_abort_start();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_settle0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
